// File: rtl/data_island_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_island_pkg
// Description : Shared constants for the HDMI data island scheduler: period
//               type encodings, island phase lengths and the preamble CTL code.
// Revision    : 1.0 - initial release
// ============================================================================
package data_island_pkg;

  // Encodings driven onto periodType.
  localparam logic [1:0] PERIOD_CONTROL     = 2'd0;
  localparam logic [1:0] PERIOD_DI_PREAMBLE = 2'd1;
  localparam logic [1:0] PERIOD_DI_GUARD    = 2'd2;
  localparam logic [1:0] PERIOD_DI_DATA     = 2'd3;

  // Island phase lengths in pixel clocks.
  localparam int PREAMBLE_LEN = 8;
  localparam int GUARD_LEN    = 2;
  localparam int PACKET_LEN   = 32;
  localparam int GAP_LEN      = 4;

  // CTL3..CTL0 pattern announcing a data island.
  localparam logic [3:0] PREAMBLE_CTL = 4'b0101;

  // One packet: header (24 bits) plus four 56-bit subpackets.
  localparam int PACKET_W = 24 + 4 * 56;

  // Down-counter reload value for a phase of the given length.
  function automatic logic [4:0] len_m1(input int len);
    return 5'(len - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/data_island_packet_fifo.sv
`default_nettype none
// ============================================================================
// Module      : data_island_packet_fifo
// Description : Two-entry packet FIFO. Ready is decoded from the registered
//               occupancy only, so it never depends on the same-cycle pop.
// Revision    : 1.0 - initial release
// ============================================================================
module data_island_packet_fifo
  import data_island_pkg::*;
#(
  parameter int WIDTH = PACKET_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic             o_empty,
  output logic [WIDTH-1:0] o_data
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign o_ready = (r_count != 2'd2);
  assign o_empty = (r_count == 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign w_push  = i_valid && o_ready;
  assign w_pop   = i_pop && !o_empty;

  // Pointer and occupancy bookkeeping; simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_pop)  r_rd_ptr <= ~r_rd_ptr;
      if (w_push && !w_pop)      r_count <= r_count + 2'd1;
      else if (w_pop && !w_push) r_count <= r_count - 2'd1;
    end
  end

  // Storage needs no reset: contents are only observed while occupancy says valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule
`default_nettype wire

// File: rtl/data_island_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : data_island_scheduler
// Description : Buffers HDMI packets and sequences one packet per data island:
//               preamble, leading guard, 32 data clocks, trailing guard, gap.
// Revision    : 1.0 - initial release
// ============================================================================
module data_island_scheduler
  import data_island_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_packetValid,
  output logic        o_packetReady,
  input  logic [23:0] i_packetHeader,
  input  logic [55:0] i_packetSubpacket0,
  input  logic [55:0] i_packetSubpacket1,
  input  logic [55:0] i_packetSubpacket2,
  input  logic [55:0] i_packetSubpacket3,
  input  logic        i_islandAllowed,
  output logic [1:0]  o_periodType,
  output logic [3:0]  o_ctl,
  output logic        o_isFirstPacketClock,
  output logic        o_isFirstIslandPacket,
  output logic [23:0] o_header,
  output logic [55:0] o_subpacket0,
  output logic [55:0] o_subpacket1,
  output logic [55:0] o_subpacket2,
  output logic [55:0] o_subpacket3,
  output logic [15:0] o_packetsSent
);

  localparam logic [2:0] ST_IDLE        = 3'd0;
  localparam logic [2:0] ST_PREAMBLE    = 3'd1;
  localparam logic [2:0] ST_LEAD_GUARD  = 3'd2;
  localparam logic [2:0] ST_DATA        = 3'd3;
  localparam logic [2:0] ST_TRAIL_GUARD = 3'd4;
  localparam logic [2:0] ST_GAP         = 3'd5;

  logic [2:0]          r_state;
  logic [2:0]          w_next_state;
  logic [4:0]          r_cnt;
  logic [4:0]          w_next_cnt;
  logic [1:0]          w_next_period;
  logic [1:0]          r_period;
  logic [3:0]          r_ctl;
  logic                r_first_clk;
  logic [PACKET_W-1:0] r_packet;
  logic [15:0]         r_packets_sent;
  logic [PACKET_W-1:0] w_head;
  logic                w_fifo_empty;
  logic                w_cnt_done;
  logic                w_start;
  logic                w_pop;

  data_island_packet_fifo #(
    .WIDTH(PACKET_W)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .i_valid(i_packetValid),
    .o_ready(o_packetReady),
    .i_data ({i_packetSubpacket3, i_packetSubpacket2, i_packetSubpacket1,
              i_packetSubpacket0, i_packetHeader}),
    .i_pop  (w_pop),
    .o_empty(w_fifo_empty),
    .o_data (w_head)
  );

  assign w_cnt_done = (r_cnt == 5'd0);
  assign w_start    = i_islandAllowed && !w_fifo_empty;
  // The packet is latched on the final leading-guard clock so it is ready for DATA cycle 0.
  assign w_pop      = (r_state == ST_LEAD_GUARD) && w_cnt_done;

  // Next-state and phase down-counter; each phase reloads the counter on entry.
  always_comb begin
    w_next_state = r_state;
    w_next_cnt   = r_cnt - 5'd1;
    case (r_state)
      ST_IDLE: begin
        w_next_cnt = 5'd0;
        if (w_start) begin
          w_next_state = ST_PREAMBLE;
          w_next_cnt   = len_m1(PREAMBLE_LEN);
        end
      end
      ST_PREAMBLE: if (w_cnt_done) begin
        w_next_state = ST_LEAD_GUARD;
        w_next_cnt   = len_m1(GUARD_LEN);
      end
      ST_LEAD_GUARD: if (w_cnt_done) begin
        w_next_state = ST_DATA;
        w_next_cnt   = len_m1(PACKET_LEN);
      end
      ST_DATA: if (w_cnt_done) begin
        w_next_state = ST_TRAIL_GUARD;
        w_next_cnt   = len_m1(GUARD_LEN);
      end
      ST_TRAIL_GUARD: if (w_cnt_done) begin
        w_next_state = ST_GAP;
        w_next_cnt   = len_m1(GAP_LEN);
      end
      ST_GAP: if (w_cnt_done) begin
        // The last gap clock doubles as the IDLE decision, so back-to-back
        // islands start exactly 48 clocks apart with 4 control clocks between.
        if (w_start) begin
          w_next_state = ST_PREAMBLE;
          w_next_cnt   = len_m1(PREAMBLE_LEN);
        end else begin
          w_next_state = ST_IDLE;
          w_next_cnt   = 5'd0;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
        w_next_cnt   = 5'd0;
      end
    endcase
  end

  // Period type for the upcoming state, registered alongside the state itself.
  always_comb begin
    w_next_period = PERIOD_CONTROL;
    case (w_next_state)
      ST_PREAMBLE:    w_next_period = PERIOD_DI_PREAMBLE;
      ST_LEAD_GUARD:  w_next_period = PERIOD_DI_GUARD;
      ST_DATA:        w_next_period = PERIOD_DI_DATA;
      ST_TRAIL_GUARD: w_next_period = PERIOD_DI_GUARD;
      default:        w_next_period = PERIOD_CONTROL;
    endcase
  end

  // State, registered outputs, packet holding register and island counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_cnt          <= 5'd0;
      r_period       <= PERIOD_CONTROL;
      r_ctl          <= 4'b0000;
      r_first_clk    <= 1'b0;
      r_packet       <= '0;
      r_packets_sent <= 16'd0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_period    <= w_next_period;
      r_ctl       <= (w_next_state == ST_PREAMBLE) ? PREAMBLE_CTL : 4'b0000;
      r_first_clk <= w_pop;
      if (w_pop) r_packet <= w_head;
      if ((r_state == ST_TRAIL_GUARD) && w_cnt_done)
        r_packets_sent <= r_packets_sent + 16'd1;
    end
  end

  assign o_periodType          = r_period;
  assign o_ctl                 = r_ctl;
  assign o_isFirstPacketClock  = r_first_clk;
  assign o_isFirstIslandPacket = 1'b1;
  assign o_header              = r_packet[23:0];
  assign o_subpacket0          = r_packet[79:24];
  assign o_subpacket1          = r_packet[135:80];
  assign o_subpacket2          = r_packet[191:136];
  assign o_subpacket3          = r_packet[247:192];
  assign o_packetsSent         = r_packets_sent;

endmodule
`default_nettype wire

// File: tb/tb_data_island_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_data_island_scheduler
// Description : Scoreboard bench: accepted packets are queued as expected
//               island payloads; a negedge monitor checks every island's
//               period/CTL sequence and payload against the queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_island_scheduler;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        valid = 1'b0;
  logic [23:0] hdr = '0;
  logic [55:0] sb0 = '0, sb1 = '0, sb2 = '0, sb3 = '0;
  logic        allowed = 1'b0;
  logic        o_packetReady;
  logic [1:0]  o_periodType;
  logic [3:0]  o_ctl;
  logic        o_isFirstPacketClock;
  logic        o_isFirstIslandPacket;
  logic [23:0] o_header;
  logic [55:0] o_subpacket0, o_subpacket1, o_subpacket2, o_subpacket3;
  logic [15:0] o_packetsSent;

  data_island_scheduler dut (
    .clk                  (clk),
    .rst                  (rst),
    .i_packetValid        (valid),
    .o_packetReady        (o_packetReady),
    .i_packetHeader       (hdr),
    .i_packetSubpacket0   (sb0),
    .i_packetSubpacket1   (sb1),
    .i_packetSubpacket2   (sb2),
    .i_packetSubpacket3   (sb3),
    .i_islandAllowed      (allowed),
    .o_periodType         (o_periodType),
    .o_ctl                (o_ctl),
    .o_isFirstPacketClock (o_isFirstPacketClock),
    .o_isFirstIslandPacket(o_isFirstIslandPacket),
    .o_header             (o_header),
    .o_subpacket0         (o_subpacket0),
    .o_subpacket1         (o_subpacket1),
    .o_subpacket2         (o_subpacket2),
    .o_subpacket3         (o_subpacket3),
    .o_packetsSent        (o_packetsSent)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic fail_now(input string name);
    n_total++;
    $display("FAIL %s: timed out (cycle %0d)", name, cyc);
  endtask

  function automatic logic [247:0] mk(input logic [23:0] h, input logic [7:0] s);
    logic [7:0] t0, t1, t2, t3;
    t0 = s; t1 = s ^ 8'h11; t2 = s ^ 8'h22; t3 = s ^ 8'h33;
    return {{7{t3}}, {7{t2}}, {7{t1}}, {7{t0}}, h};
  endfunction

  // Expected periodType at offset p within a 48-clock island.
  function automatic logic [1:0] exp_period(input int p);
    if (p < 8)  return 2'd1;
    if (p < 10) return 2'd2;
    if (p < 42) return 2'd3;
    if (p < 44) return 2'd2;
    return 2'd0;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  logic [247:0] exp_q[$];
  int           starts[$];
  int           pos = 0;
  bit           expect_idle = 1'b0;
  logic [247:0] held = '0;

  always @(negedge clk) begin
    logic [247:0] cur;
    cur = {o_subpacket3, o_subpacket2, o_subpacket1, o_subpacket0, o_header};
    if (rst) begin
      pos = 0;
    end else if (pos != 0 || o_periodType != 2'd0) begin
      if (pos == 0) starts.push_back(cyc);
      check($sformatf("period[%0d]", pos), o_periodType, exp_period(pos));
      check($sformatf("ctl[%0d]", pos), o_ctl, (pos < 8) ? 4'b0101 : 4'b0000);
      check($sformatf("first_clk[%0d]", pos), o_isFirstPacketClock, (pos == 10));
      if (pos == 10) begin
        held = cur;
        if (exp_q.size() == 0) fail_now("packet_unexpected");
        else check("packet", cur, exp_q.pop_front());
      end
      if (pos == 41) check("packet_hold", cur, held);
      pos = (pos == 47) ? 0 : pos + 1;
    end else if (expect_idle) begin
      check("idle_period", o_periodType, 2'd0);
      check("idle_first_clk", o_isFirstPacketClock, 1'b0);
    end
  end

  // ---------------- stimulus ----------------
  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [247:0] d, output int acc);
    int n;
    n = 0;
    valid = 1'b1;
    {sb3, sb2, sb1, sb0, hdr} = d;
    while (!o_packetReady && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!o_packetReady) begin
      fail_now("send_accept");
      acc = -1;
    end else begin
      acc = cyc;
      exp_q.push_back(d);
      @(negedge clk);
    end
  endtask

  task automatic wait_first(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (o_isFirstPacketClock) ok = 1'b1;
    end
    if (!ok) fail_now("wait_first_clk");
  endtask

  initial begin
    int a1, a2, a3, c0, b, r;
    bit ok;

    #2 rst = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_period", o_periodType, 2'd0);
    check("rst_ctl", o_ctl, 4'd0);
    check("rst_first_clk", o_isFirstPacketClock, 1'b0);
    check("rst_header", o_header, 24'd0);
    check("rst_sub3", o_subpacket3, 56'd0);
    check("rst_sent", o_packetsSent, 16'd0);
    check("rst_ready", o_packetReady, 1'b1);
    check("first_island_pkt", o_isFirstIslandPacket, 1'b1);

    // Single packet, first preamble 2 cycles after reset release
    allowed = 1'b1;
    rst = 1'b0;
    c0 = cyc;
    b = starts.size();
    send(mk(24'h0D0282, 8'hA1), a1);
    valid = 1'b0;
    repeat (60) @(negedge clk);
    check("single_islands", starts.size() - b, 1);
    if (starts.size() > b) check("single_start_lat", starts[b] - c0, 2);
    check("single_sent", o_packetsSent, 16'd1);

    // Three packets back-to-back
    b = starts.size();
    send(mk(24'h000001, 8'h10), a1);
    send(mk(24'h000002, 8'h20), a2);
    check("ready_when_full", o_packetReady, 1'b0);
    send(mk(24'h000003, 8'h30), a3);
    valid = 1'b0;
    check("second_accept", a2 - a1, 1);
    check("third_accept", a3 - a1, 12);
    repeat (160) @(negedge clk);
    check("b2b_islands", starts.size() - b, 3);
    if (starts.size() >= b + 3) begin
      check("b2b_spacing1", starts[b+1] - starts[b], 48);
      check("b2b_spacing2", starts[b+2] - starts[b+1], 48);
    end
    check("b2b_sent", o_packetsSent, 16'd4);

    // Packet waiting while islands are not allowed
    allowed = 1'b0;
    b = starts.size();
    send(mk(24'h0A0B0C, 8'h44), a1);
    valid = 1'b0;
    expect_idle = 1'b1;
    repeat (100) @(negedge clk);
    expect_idle = 1'b0;
    check("held_no_island", starts.size() - b, 0);
    r = cyc;
    allowed = 1'b1;
    repeat (60) @(negedge clk);
    check("late_islands", starts.size() - b, 1);
    if (starts.size() > b) check("late_start_lat", starts[b] - r, 1);
    check("late_sent", o_packetsSent, 16'd5);

    // islandAllowed dropped mid-island
    b = starts.size();
    send(mk(24'h123456, 8'h55), a1);
    valid = 1'b0;
    wait_first(ok);
    repeat (5) @(negedge clk);
    allowed = 1'b0;
    repeat (50) @(negedge clk);
    check("drop_islands", starts.size() - b, 1);
    check("drop_sent", o_packetsSent, 16'd6);
    allowed = 1'b1;

    // Reset during DATA cycle 10
    send(mk(24'h654321, 8'h66), a1);
    valid = 1'b0;
    wait_first(ok);
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_period", o_periodType, 2'd0);
    check("mid_rst_ctl", o_ctl, 4'd0);
    check("mid_rst_header", o_header, 24'd0);
    check("mid_rst_sub0", o_subpacket0, 56'd0);
    check("mid_rst_sent", o_packetsSent, 16'd0);
    check("mid_rst_ready", o_packetReady, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    b = starts.size();
    repeat (10) @(negedge clk);
    check("post_rst_idle", o_periodType, 2'd0);
    check("post_rst_no_island", starts.size() - b, 0);

    // Counter wrap
    force dut.r_packets_sent = 16'hFFFF;
    @(negedge clk);
    release dut.r_packets_sent;
    @(negedge clk);
    check("wrap_preload", o_packetsSent, 16'hFFFF);
    send(mk(24'hABCDEF, 8'h77), a1);
    valid = 1'b0;
    repeat (60) @(negedge clk);
    check("wrap_sent", o_packetsSent, 16'h0000);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
